// File: rtl/game_sequencer.sv
// game_sequencer: Dino Run play-state controller (idle, collision clear, run, dying, game over).
// Optional best-score register is built only when GAME_SEQ_HIGH_SCORE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, collision unit held in clear
// ARM   | collision unit clear pulse, CLR_CYCLES clocks
// RUN   | world scrolling, score and speed advancing
// DYING | death animation, dino blinks, DEATH_FRAMES ticks
// OVER  | score frozen, waiting for restart
module game_sequencer #(
  parameter int CLR_CYCLES   = 4,
  parameter int SCORE_DIV    = 6,
  parameter int DEATH_FRAMES = 60,
  parameter int SPEED_STEP   = 100,
  parameter int MAX_SPEED    = 7
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start_btn,
  input  logic        frame_tick,
  input  logic        is_alive,
  output logic        collide_clr,
  output logic        run_en,
  output logic        dino_visible,
  output logic        game_over,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [2:0]  speed_level,
  output logic [15:0] high_score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DYING = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int SPW = $clog2(SPEED_STEP + 1);

  localparam logic [3:0]     ARM_LOAD  = 4'(CLR_CYCLES - 1);
  localparam logic [5:0]     DIV_LAST  = 6'(SCORE_DIV - 1);
  localparam logic [7:0]     DEATH_END = 8'(DEATH_FRAMES);
  localparam logic [SPW-1:0] SPD_LAST  = SPW'(SPEED_STEP - 1);
  localparam logic [SPW-1:0] SPD_ONE   = SPW'(1);
  localparam logic [2:0]     SPEED_MAX = 3'(MAX_SPEED);
  localparam logic [15:0]    SCORE_MAX = 16'h9999;

  logic [2:0]     state_q, state_d;
  logic           start_prev_q;
  logic           start_press;
  logic [3:0]     arm_cnt_q, arm_cnt_d;
  logic           first_run_q, first_run_d;
  logic [5:0]     div_cnt_q, div_cnt_d;
  logic [SPW-1:0] spd_cnt_q, spd_cnt_d;
  logic [7:0]     death_cnt_q, death_cnt_d;
  logic [7:0]     death_inc;
  logic [15:0]    score_q, score_d;
  logic [2:0]     speed_q, speed_d;
  logic           clear_round;

  logic           collide_clr_q, collide_clr_d;
  logic           run_en_q, run_en_d;
  logic           dino_vis_q, dino_vis_d;
  logic           game_over_q, game_over_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_press = start_btn & ~start_prev_q;
  assign death_inc   = death_cnt_q + {7'd0, frame_tick};

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    first_run_d = 1'b0;
    div_cnt_d   = div_cnt_q;
    spd_cnt_d   = spd_cnt_q;
    death_cnt_d = death_cnt_q;
    score_d     = score_q;
    speed_d     = speed_q;
    clear_round = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_press) begin
          state_d     = S_ARM;
          arm_cnt_d   = ARM_LOAD;
          clear_round = 1'b1;
        end
      end
      S_ARM: begin
        if (arm_cnt_q == 4'd0) begin
          state_d     = S_RUN;
          first_run_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q - 4'd1;
        end
      end
      S_RUN: begin
        // First RUN clock ignores is_alive: collision history is one cycle stale.
        if (!first_run_q && !is_alive) begin
          state_d     = S_DYING;
          death_cnt_d = {7'd0, frame_tick};
        end
      end
      S_DYING: begin
        death_cnt_d = death_inc;
        if (death_inc >= DEATH_END) begin
          state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_round) begin
      score_d   = '0;
      speed_d   = '0;
      div_cnt_d = '0;
      spd_cnt_d = '0;
    end

    // Keyed on the destination so a tick on the ARM->RUN edge is counted, and death blocks scoring.
    if (state_d == S_RUN && frame_tick) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        if (score_q != SCORE_MAX) begin
          score_d = bcd_inc(score_q);
          if (spd_cnt_q == SPD_LAST) begin
            spd_cnt_d = '0;
            if (speed_q < SPEED_MAX) begin
              speed_d = speed_q + 3'd1;
            end
          end else begin
            spd_cnt_d = spd_cnt_q + SPD_ONE;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    collide_clr_d = (state_d == S_IDLE) || (state_d == S_ARM) || (state_d == S_OVER);
    run_en_d      = (state_d == S_RUN);
    game_over_d   = (state_d == S_OVER);
    dino_vis_d    = (state_d == S_DYING) ? ~death_cnt_d[3] : 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= S_IDLE;
      start_prev_q  <= 1'b1;
      arm_cnt_q     <= '0;
      first_run_q   <= 1'b0;
      div_cnt_q     <= '0;
      spd_cnt_q     <= '0;
      death_cnt_q   <= '0;
      score_q       <= '0;
      speed_q       <= '0;
      collide_clr_q <= 1'b1;
      run_en_q      <= 1'b0;
      dino_vis_q    <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_btn;
      arm_cnt_q     <= arm_cnt_d;
      first_run_q   <= first_run_d;
      div_cnt_q     <= div_cnt_d;
      spd_cnt_q     <= spd_cnt_d;
      death_cnt_q   <= death_cnt_d;
      score_q       <= score_d;
      speed_q       <= speed_d;
      collide_clr_q <= collide_clr_d;
      run_en_q      <= run_en_d;
      dino_vis_q    <= dino_vis_d;
      game_over_q   <= game_over_d;
    end
  end

`ifdef GAME_SEQ_HIGH_SCORE_EN
  logic [15:0] high_score_q;

  // Packed valid BCD orders the same as its decimal value, so a plain compare is digit-3-first.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      high_score_q <= '0;
    end else if (state_q == S_DYING && state_d == S_OVER && score_q > high_score_q) begin
      high_score_q <= score_q;
    end
  end

  assign high_score = high_score_q;
`else
  assign high_score = 16'h0000;
`endif

  assign collide_clr  = collide_clr_q;
  assign run_en       = run_en_q;
  assign dino_visible = dino_vis_q;
  assign game_over    = game_over_q;
  assign state        = state_q;
  assign score        = score_q;
  assign speed_level  = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized play checked against a round-level model.
module tb_game_sequencer;

  localparam int CLR_CYCLES   = 4;
  localparam int SCORE_DIV    = 6;
  localparam int DEATH_FRAMES = 60;
  localparam int SPEED_STEP   = 100;
  localparam int MAX_SPEED    = 7;

`ifdef GAME_SEQ_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  logic start_btn, frame_tick, is_alive;
  logic collide_clr, run_en, dino_visible, game_over;
  logic [2:0] state, speed_level;
  logic [15:0] score, high_score;

  logic f_btn, f_tick, f_alive;
  logic f_collide_clr, f_run_en, f_dino_visible, f_game_over;
  logic [2:0] f_state, f_speed_level;
  logic [15:0] f_score, f_high_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .clr(clr), .start_btn(start_btn), .frame_tick(frame_tick), .is_alive(is_alive),
    .collide_clr(collide_clr), .run_en(run_en), .dino_visible(dino_visible), .game_over(game_over),
    .state(state), .score(score), .speed_level(speed_level), .high_score(high_score)
  );

  game_sequencer #(.SCORE_DIV(1)) dut_f (
    .clk(clk), .clr(clr), .start_btn(f_btn), .frame_tick(f_tick), .is_alive(f_alive),
    .collide_clr(f_collide_clr), .run_en(f_run_en), .dino_visible(f_dino_visible), .game_over(f_game_over),
    .state(f_state), .score(f_score), .speed_level(f_speed_level), .high_score(f_high_score)
  );

  // Round-level reference: phase, counted run ticks and dying ticks; score derived arithmetically.
  int m_phase, m_arm_clks, m_run_clks, m_run_ticks, m_die_ticks, m_hs_pts;
  bit m_prev_btn;

  function automatic int m_points();
    int p;
    p = m_run_ticks / SCORE_DIV;
    return (p > 9999) ? 9999 : p;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [2:0] m_speed();
    int s;
    s = m_points() / SPEED_STEP;
    if (s > MAX_SPEED) s = MAX_SPEED;
    return 3'(s);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_arm_clks = 0; m_run_clks = 0; m_run_ticks = 0;
    m_die_ticks = 0; m_hs_pts = 0; m_prev_btn = 1'b1;
  endfunction

  function automatic void model_step();
    bit press;
    press = start_btn && !m_prev_btn;
    m_prev_btn = start_btn;
    case (m_phase)
      0, 4: if (press) begin m_phase = 1; m_arm_clks = 0; m_run_ticks = 0; end
      1: begin
        m_arm_clks++;
        if (m_arm_clks == CLR_CYCLES) begin
          m_phase = 2; m_run_clks = 0;
          if (frame_tick) m_run_ticks++;
        end
      end
      2: begin
        if (m_run_clks > 0 && !is_alive) begin
          m_phase = 3; m_die_ticks = frame_tick ? 1 : 0;
        end else if (frame_tick) begin
          m_run_ticks++;
        end
        m_run_clks++;
      end
      3: begin
        if (frame_tick) m_die_ticks++;
        if (m_die_ticks >= DEATH_FRAMES) begin
          m_phase = 4;
          if (HS_EN && m_points() > m_hs_pts) m_hs_pts = m_points();
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!clr) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0; start_btn = 1'b1; frame_tick = 1'b0; is_alive = 1'b1;
    f_btn = 1'b1; f_tick = 1'b0; f_alive = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (collide_clr !== 1'b1) begin errors++; $display("FAIL reset_collide_clr: got %b expected 1", collide_clr); end
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en: got %b expected 0", run_en); end
    checks++; if (dino_visible !== 1'b1) begin errors++; $display("FAIL reset_dino_visible: got %b expected 1", dino_visible); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h expected 0000", score); end
    checks++; if (speed_level !== 3'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed_level); end
    checks++; if (high_score !== 16'h0000) begin errors++; $display("FAIL reset_high_score: got %h expected 0000", high_score); end
    clr = 1'b1;
    repeat (3) cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_button_no_start: got %0d expected 0", state); end
    start_btn = 1'b0; f_btn = 1'b0;
    cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL release_no_start: got %0d expected 0", state); end
  endtask

  task automatic test_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    for (int i = 0; i < CLR_CYCLES; i++) begin
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL arm_state[%0d]: got %0d expected 1", i, state); end
      checks++; if (collide_clr !== 1'b1) begin errors++; $display("FAIL arm_collide_clr[%0d]: got %b expected 1", i, collide_clr); end
      cyc();
    end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL run_entry_state: got %0d expected 2", state); end
    checks++; if (collide_clr !== 1'b0) begin errors++; $display("FAIL run_collide_clr: got %b expected 0", collide_clr); end
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL run_en_high: got %b expected 1", run_en); end
  endtask

  task automatic test_collision();
    start_btn = 1'b1; is_alive = 1'b0; frame_tick = 1'b0;
    cyc();
    start_btn = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL first_run_clock_masked: got %0d expected 2", state); end
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL first_run_clock_run_en: got %b expected 1", run_en); end
    cyc();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL death_state: got %0d expected 3", state); end
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL death_run_en: got %b expected 0", run_en); end
    is_alive = 1'b1; frame_tick = 1'b1;
    for (int i = 1; i <= DEATH_FRAMES; i++) begin
      start_btn = (i == 10);
      cyc();
      if (i < DEATH_FRAMES) begin
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL dying_state[%0d]: got %0d expected 3", i, state); end
        checks++;
        if (dino_visible !== (((i / 8) % 2) == 0)) begin
          errors++; $display("FAIL dying_blink[%0d]: got %b expected %b", i, dino_visible, ((i / 8) % 2) == 0);
        end
      end else begin
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL over_state: got %0d expected 4", state); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_game_over: got %b expected 1", game_over); end
        checks++; if (dino_visible !== 1'b1) begin errors++; $display("FAIL over_visible: got %b expected 1", dino_visible); end
        checks++; if (collide_clr !== 1'b1) begin errors++; $display("FAIL over_collide_clr: got %b expected 1", collide_clr); end
      end
    end
    start_btn = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic test_death_tie();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_arm: got %0d expected 1", state); end
    repeat (CLR_CYCLES) cyc();
    frame_tick = 1'b1; is_alive = 1'b1;
    repeat (SCORE_DIV - 1) cyc();
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL tie_pre_score: got %h expected 0000", score); end
    is_alive = 1'b0;
    cyc();
    is_alive = 1'b1;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL tie_state: got %0d expected 3", state); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL tie_score: got %h expected 0000", score); end
  endtask

  task automatic test_reset_mid_dying();
    frame_tick = 1'b1;
    repeat (3) cyc();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pre_reset_dying: got %0d expected 3", state); end
    #2 clr = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", state); end
    checks++; if (collide_clr !== 1'b1) begin errors++; $display("FAIL async_reset_collide: got %b expected 1", collide_clr); end
    checks++; if (dino_visible !== 1'b1) begin errors++; $display("FAIL async_reset_visible: got %b expected 1", dino_visible); end
    checks++; if (run_en !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got %b%b expected 00", run_en, game_over); end
    checks++; if (score !== 16'h0000 || speed_level !== 3'd0 || high_score !== 16'h0000) begin
      errors++; $display("FAIL async_reset_values: got %h %0d %h expected 0000 0 0000", score, speed_level, high_score);
    end
    model_reset();
    frame_tick = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    cyc();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got %0d expected 0", state); end
  endtask

  task automatic play_round(input int pts);
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    repeat (CLR_CYCLES) cyc();
    is_alive = 1'b1; frame_tick = 1'b1;
    repeat (pts * SCORE_DIV) cyc();
    frame_tick = 1'b0; is_alive = 1'b0;
    cyc();
    is_alive = 1'b1; frame_tick = 1'b1;
    repeat (DEATH_FRAMES) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic test_high_score();
    play_round(42);
    checks++; if (state !== 3'd4 || score !== 16'h0042) begin errors++; $display("FAIL round1_end: got %0d %h expected 4 0042", state, score); end
    checks++; if (high_score !== (HS_EN ? 16'h0042 : 16'h0000)) begin
      errors++; $display("FAIL round1_high_score: got %h expected %h", high_score, HS_EN ? 16'h0042 : 16'h0000);
    end
    play_round(17);
    checks++; if (score !== 16'h0017) begin errors++; $display("FAIL round2_score: got %h expected 0017", score); end
    checks++; if (high_score !== (HS_EN ? 16'h0042 : 16'h0000)) begin
      errors++; $display("FAIL round2_high_score: got %h expected %h", high_score, HS_EN ? 16'h0042 : 16'h0000);
    end
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    checks++; if (state !== 3'd1 || score !== 16'h0000) begin errors++; $display("FAIL restart_clear: got %0d %h expected 1 0000", state, score); end
    checks++; if (high_score !== (HS_EN ? 16'h0042 : 16'h0000)) begin
      errors++; $display("FAIL restart_keeps_high: got %h expected %h", high_score, HS_EN ? 16'h0042 : 16'h0000);
    end
    repeat (CLR_CYCLES) cyc();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL rearm_run: got %0d expected 2", state); end
  endtask

  task automatic test_score();
    frame_tick = 1'b1; is_alive = 1'b1;
    repeat (60) cyc();
    checks++; if (score !== 16'h0010) begin errors++; $display("FAIL score_60_ticks: got %h expected 0010", score); end
    repeat (534) cyc();
    checks++; if (score !== 16'h0099 || speed_level !== 3'd0) begin errors++; $display("FAIL score_99: got %h %0d expected 0099 0", score, speed_level); end
    repeat (6) cyc();
    checks++; if (score !== 16'h0100 || speed_level !== 3'd1) begin errors++; $display("FAIL score_100: got %h %0d expected 0100 1", score, speed_level); end
    repeat (5394) cyc();
    checks++; if (score !== 16'h0999 || speed_level !== 3'd7) begin errors++; $display("FAIL score_999: got %h %0d expected 0999 7", score, speed_level); end
    repeat (6) cyc();
    checks++; if (score !== 16'h1000 || speed_level !== 3'd7) begin errors++; $display("FAIL score_carry: got %h %0d expected 1000 7", score, speed_level); end
    checks++; if (score !== to_bcd(m_points())) begin errors++; $display("FAIL score_model: got %h expected %h", score, to_bcd(m_points())); end
    frame_tick = 1'b0; is_alive = 1'b0;
    cyc();
    is_alive = 1'b1; frame_tick = 1'b1;
    repeat (DEATH_FRAMES) cyc();
    frame_tick = 1'b0;
    checks++; if (state !== 3'd4 || high_score !== (HS_EN ? 16'h1000 : 16'h0000)) begin
      errors++; $display("FAIL score_round_over: got %0d %h expected 4 %h", state, high_score, HS_EN ? 16'h1000 : 16'h0000);
    end
  endtask

  task automatic test_saturation();
    f_btn = 1'b1;
    cyc();
    f_btn = 1'b0;
    repeat (CLR_CYCLES) cyc();
    f_alive = 1'b1; f_tick = 1'b1;
    repeat (9998) cyc();
    checks++; if (f_score !== 16'h9998) begin errors++; $display("FAIL sat_9998: got %h expected 9998", f_score); end
    cyc();
    checks++; if (f_score !== 16'h9999) begin errors++; $display("FAIL sat_9999: got %h expected 9999", f_score); end
    repeat (20) cyc();
    checks++; if (f_score !== 16'h9999) begin errors++; $display("FAIL sat_hold: got %h expected 9999", f_score); end
    checks++; if (f_speed_level !== 3'd7) begin errors++; $display("FAIL sat_speed: got %0d expected 7", f_speed_level); end
    checks++; if (f_state !== 3'd2 || f_run_en !== 1'b1 || f_collide_clr !== 1'b0) begin
      errors++; $display("FAIL sat_run_flags: got %0d %b %b expected 2 1 0", f_state, f_run_en, f_collide_clr);
    end
    checks++; if (f_game_over !== 1'b0 || f_dino_visible !== 1'b1 || f_high_score !== 16'h0000) begin
      errors++; $display("FAIL sat_misc: got %b %b %h expected 0 1 0000", f_game_over, f_dino_visible, f_high_score);
    end
    f_tick = 1'b0;
  endtask

  task automatic test_random();
    int pts;
    logic [2:0] e_state;
    logic e_cc, e_run, e_vis, e_go;
    logic [15:0] e_hs;
    for (int n = 0; n < 4000; n++) begin
      start_btn  = ($urandom_range(0, 9) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      is_alive   = ($urandom_range(0, 59) != 0);
      cyc();
      pts     = m_points();
      e_state = 3'(m_phase);
      e_cc    = (m_phase == 0) || (m_phase == 1) || (m_phase == 4);
      e_run   = (m_phase == 2);
      e_go    = (m_phase == 4);
      e_vis   = (m_phase == 3) ? (((m_die_ticks / 8) % 2) == 0) : 1'b1;
      e_hs    = HS_EN ? to_bcd(m_hs_pts) : 16'h0000;
      checks++; if (state !== e_state) begin errors++; $display("FAIL rnd_state@%0d: got %0d expected %0d", n, state, e_state); end
      checks++; if (collide_clr !== e_cc) begin errors++; $display("FAIL rnd_collide_clr@%0d: got %b expected %b", n, collide_clr, e_cc); end
      checks++; if (run_en !== e_run) begin errors++; $display("FAIL rnd_run_en@%0d: got %b expected %b", n, run_en, e_run); end
      checks++; if (game_over !== e_go) begin errors++; $display("FAIL rnd_game_over@%0d: got %b expected %b", n, game_over, e_go); end
      checks++; if (dino_visible !== e_vis) begin errors++; $display("FAIL rnd_visible@%0d: got %b expected %b", n, dino_visible, e_vis); end
      checks++; if (score !== to_bcd(pts)) begin errors++; $display("FAIL rnd_score@%0d: got %h expected %h", n, score, to_bcd(pts)); end
      checks++; if (speed_level !== m_speed()) begin errors++; $display("FAIL rnd_speed@%0d: got %0d expected %0d", n, speed_level, m_speed()); end
      checks++; if (high_score !== e_hs) begin errors++; $display("FAIL rnd_high_score@%0d: got %h expected %h", n, high_score, e_hs); end
    end
    start_btn = 1'b0; frame_tick = 1'b0; is_alive = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_collision();
    test_death_tie();
    test_reset_mid_dying();
    test_high_score();
    test_score();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level play-state controller for Dino Run.
- Sequences each round: idle, collision-unit clear, running, death animation, game over, restart.
- Drives the collision unit's clear, gates world scrolling, and keeps the BCD score, speed level and optional high score.
- Sits between the button inputs, the collision unit (consumes is_alive) and the obstacle, enemy and display logic.

Parameters:
- CLR_CYCLES, 4: clocks collide_clr is held high in ARM (1..15).
- SCORE_DIV, 6: frame ticks per score point in RUN (1..63).
- DEATH_FRAMES, 60: frame ticks spent in DYING (1..255).
- SPEED_STEP, 100: score points per speed_level increment (binary count).
- MAX_SPEED, 7: speed_level ceiling (≤7).

Ports:
- clk, input, 1: system clock.
- clr, input, 1: asynchronous active-low reset. Asserted when 0.
- start_btn, input, 1: start/restart button, already synchronised and debounced, level.
- frame_tick, input, 1: one-clock pulse per video frame.
- is_alive, input, 1: sticky alive flag from the collision unit.
- collide_clr, output, 1: active-high clear to the collision unit.
- run_en, output, 1: world scroll/physics enable.
- dino_visible, output, 1: dino sprite enable (blinks while dying).
- game_over, output, 1: high in OVER.
- state, output, 3: encoded FSM state for display/debug.
- score, output, 16: 4-digit BCD score, digit 3 in [15:12].
- speed_level, output, 3: difficulty level for obstacle speed.
- high_score, output, 16: BCD best score (feature-dependent).

Behaviour:
- Reset (clr=0, async):
  - state=IDLE.
  - collide_clr=1, run_en=0, dino_visible=1, game_over=0.
  - score=0, speed_level=0, high_score=0.
  - All internal counters 0; start edge register = 1, so a button held through reset does not fire.
- start_press is a rising edge of start_btn (registered previous value). It is internal and one clock long.
- State encoding: IDLE=0, ARM=1, RUN=2, DYING=3, OVER=4. Codes 5..7 go to IDLE on the next clock.
- IDLE:
  - Outputs: collide_clr=1, run_en=0, dino_visible=1.
  - start_press -> ARM. The transition clears score, speed_level and the point and speed counters.
- ARM:
  - collide_clr=1, run_en=0.
  - Counts CLR_CYCLES clocks, then -> RUN. ARM therefore lasts exactly CLR_CYCLES clocks.
- RUN:
  - collide_clr=0, run_en=1.
  - is_alive is sampled every clock, except the first clock of RUN (masked, because collision shift registers are one cycle stale).
  - is_alive=0 (sampled) -> DYING on the next clock, run_en=0 from that clock.
  - frame_tick increments the frame divider. When the divider reaches SCORE_DIV-1, it wraps to 0 and score increments by 1 BCD.
  - BCD increment: each digit wraps 9->0 with carry. The score saturates at 9999 (no wrap to 0000).
  - Each score increment also increments the speed counter. When the speed counter reaches SPEED_STEP, it resets to 0 and speed_level increments, saturating at MAX_SPEED.
  - If death and a score increment fall on the same clock, death wins: no score increment on that clock.
  - start_press is ignored.
- DYING:
  - run_en=0, collide_clr=0.
  - The death counter increments per frame_tick.
  - dino_visible toggles on every 8th frame tick (death counter bit 3 inverted).
  - After DEATH_FRAMES ticks -> OVER.
  - start_press is ignored.
- OVER:
  - game_over=1, dino_visible=1, run_en=0, collide_clr=1.
  - score and speed_level are held.
  - start_press -> ARM. This clears score and speed_level but not high_score.
- Outputs are registered, so state-dependent outputs change on the same edge as state.
- frame_tick coinciding with a state transition is consumed by the destination state only if that state counts ticks. It is never double-counted.
- Reset mid-round returns to IDLE immediately and zeroes high_score.

Optional Feature:
- Macro: GAME_SEQ_HIGH_SCORE_EN.
- When defined:
  - On the DYING->OVER transition, if score > high_score (BCD compare, digit 3 first), high_score <= score.
  - high_score is held across rounds.
- When undefined:
  - high_score is tied to 16'h0000 and no comparison logic is built.

Test Plan:
- Reset, then release clr, then one start_btn press:
  - state goes 0 -> 1 -> 2.
  - collide_clr high for exactly 4 clocks after the press edge, then low.
  - run_en=1 in RUN.
- RUN with SCORE_DIV=6:
  - After 60 frame ticks, score=16'h0010.
  - Preload to 0x0999, then 6 more ticks: score=0x1000.
  - At 0x9999, further ticks keep 0x9999.
- Speed level: after 100 score points, speed_level=1. After 800 points, speed_level=7 and stays 7.
- Collision handling:
  - Drive is_alive=0 on the first RUN clock: no effect.
  - Drive is_alive=0 later: DYING next clock, run_en=0.
  - dino_visible toggles every 8 ticks.
  - After 60 ticks, OVER with game_over=1.
  - Death on the same clock as the 6th tick: score is not incremented.
- With GAME_SEQ_HIGH_SCORE_EN:
  - Round 1 ends at 0x0042: high_score=0x0042.
  - Round 2 ends at 0x0017: high_score stays 0x0042.
  - A restart press in OVER clears score to 0 and enters ARM.
- Button held through reset: no start. Button pressed during RUN/DYING: ignored.
- Assert clr=0 mid-DYING: asynchronous return to IDLE with all outputs at reset values.
